// File: rtl/mem_burst_master.sv
// Block load/store initiator for the word-addressed data memory.
// Sequences 1-16 word bursts with range checking and valid/ready data streams.
module mem_burst_master #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned DEPTH     = 65536
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,

  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,

  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_last,

  output logic        done,
  output logic        err,

  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] Address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StRdOut = 2'd2;
  localparam logic [1:0] StWrite = 2'd3;

  localparam logic [32:0] BaseAddr  = 33'(BASE_ADDR);
  localparam logic [32:0] LimitAddr = 33'(BASE_ADDR) + (33'(DEPTH - 1) << 2);

  logic [1:0]  state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  // Keeps req_ready low until the first edge after reset release.
  logic        alive_q, alive_d;

  logic [31:0] req_aligned;
  logic [32:0] req_end;
  logic        range_bad;

  assign req_aligned = req_addr & 32'hFFFF_FFFC;
  // 33-bit sum so a start near the top of the address space cannot wrap past the check.
  assign req_end     = {1'b0, req_aligned} + {27'd0, req_len, 2'b00};
  assign range_bad   = ({1'b0, req_aligned} < BaseAddr) || (req_end > LimitAddr);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    last_d     = last_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    alive_d    = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (req_valid && alive_q) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            cur_addr_d = req_aligned;
            cnt_d      = req_len;
            state_d    = req_write ? StWrite : StRead;
          end
        end
      end
      StRead: begin
        rdata_d = readData;
        last_d  = (cnt_q == 4'd0);
        state_d = StRdOut;
      end
      StRdOut: begin
        if (rdata_ready) begin
          if (last_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cur_addr_d = cur_addr_q + 32'd4;
            cnt_d      = cnt_q - 4'd1;
            state_d    = StRead;
          end
        end
      end
      StWrite: begin
        if (wdata_valid) begin
          if (cnt_q == 4'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cur_addr_d = cur_addr_q + 32'd4;
            cnt_d      = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cur_addr_q <= 32'd0;
      cnt_q      <= 4'd0;
      rdata_q    <= 32'd0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      alive_q    <= alive_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    req_ready   = alive_q && (state_q == StIdle);
    memRead     = (state_q == StRead);
    wdata_ready = (state_q == StWrite);
    memWrite    = (state_q == StWrite) && wdata_valid;
    writeData   = (state_q == StWrite) ? wdata : 32'd0;
    Address     = (state_q == StIdle) ? 32'd0 : cur_addr_q;
    rdata_valid = (state_q == StRdOut);
    rdata       = rdata_q;
    rdata_last  = last_q;
    done        = done_q;
    err         = err_q;
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master: range/alignment vector table plus
// hand-written store, backpressured load, stall and mid-burst reset sequences.
`timescale 1ns/1ps
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [3:0]  req_len = 4'd0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = 32'd0;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        done;
  logic        err;
  logic        memRead;
  logic        memWrite;
  logic [31:0] Address;
  logic [31:0] writeData;
  logic [31:0] readData;

  int vectors = 0;
  int miscompares = 0;
  int rd_strobes = 0;
  int rd0;

  always #5 clk = ~clk;

  mem_burst_master #(
    .BASE_ADDR (1024),
    .DEPTH     (65536)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .rdata_last  (rdata_last),
    .done        (done),
    .err         (err),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .Address     (Address),
    .writeData   (writeData),
    .readData    (readData)
  );

  // Data memory model: word 0 at byte 1024, combinational read.
  logic [31:0] mem [0:65535];
  logic [15:0] mem_idx;
  assign mem_idx  = 16'((Address - 32'd1024) >> 2);
  assign readData = memRead ? mem[mem_idx] : 32'd0;

  always @(posedge clk) begin
    if (memWrite) mem[mem_idx] <= writeData;
    if (memRead) rd_strobes <= rd_strobes + 1;
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic        exp_err;
    logic [31:0] exp_addr;
  } range_vec_t;

  range_vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctl_bits();
    return {24'd0, req_ready, memRead, memWrite, wdata_ready,
            rdata_valid, rdata_last, done, err};
  endfunction

  initial begin
    vecs[0] = '{addr: 32'd1030,       len: 4'd0,  exp_err: 1'b0, exp_addr: 32'd1028};
    vecs[1] = '{addr: 32'd1000,       len: 4'd0,  exp_err: 1'b1, exp_addr: 32'd0};
    vecs[2] = '{addr: 32'd263164,     len: 4'd0,  exp_err: 1'b0, exp_addr: 32'd263164};
    vecs[3] = '{addr: 32'd263164,     len: 4'd1,  exp_err: 1'b1, exp_addr: 32'd0};
    vecs[4] = '{addr: 32'd1020,       len: 4'd0,  exp_err: 1'b1, exp_addr: 32'd0};
    vecs[5] = '{addr: 32'd263160,     len: 4'd1,  exp_err: 1'b0, exp_addr: 32'd263160};
    vecs[6] = '{addr: 32'd1024,       len: 4'd15, exp_err: 1'b0, exp_addr: 32'd1024};
    vecs[7] = '{addr: 32'hFFFF_FFF0,  len: 4'd15, exp_err: 1'b1, exp_addr: 32'd0};
    vecs[8] = '{addr: 32'd1027,       len: 4'd2,  exp_err: 1'b0, exp_addr: 32'd1024};

    // Reset state
    @(negedge clk);
    chk("reset_ctl", ctl_bits(), 32'd0);
    chk("reset_addr", Address, 32'd0);
    chk("reset_wdata_bus", writeData, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("post_reset_ready", req_ready, 32'd1);
    step();

    // Store burst 5,6,7,8 at 1024
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd1024; req_len = 4'd3;
    @(negedge clk);
    chk("st_req_ready", req_ready, 32'd1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wdata_valid = 1'b1; wdata = 32'(5 + i);
      @(negedge clk);
      chk($sformatf("st%0d_memwrite", i), memWrite, 32'd1);
      chk($sformatf("st%0d_addr", i), Address, 32'(1024 + 4 * i));
      chk($sformatf("st%0d_wbus", i), writeData, 32'(5 + i));
      chk($sformatf("st%0d_done", i), done, 32'd0);
      step();
    end
    wdata_valid = 1'b0;
    @(negedge clk);
    chk("st_done", done, 32'd1);
    chk("st_idle_addr", Address, 32'd0);
    chk("st_idle_ready", req_ready, 32'd1);
    chk("st_idle_memwrite", memWrite, 32'd0);
    step();
    @(negedge clk);
    chk("st_done_pulse", done, 32'd0);
    step();

    // Load burst with rdata_ready toggling 0,1
    rd0 = rd_strobes;
    rdata_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1024; req_len = 4'd3;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ld%0d_memread", i), memRead, 32'd1);
      chk($sformatf("ld%0d_addr", i), Address, 32'(1024 + 4 * i));
      chk($sformatf("ld%0d_rvalid_rd", i), rdata_valid, 32'd0);
      step();
      @(negedge clk);
      chk($sformatf("ld%0d_rvalid", i), rdata_valid, 32'd1);
      chk($sformatf("ld%0d_memread_out", i), memRead, 32'd0);
      chk($sformatf("ld%0d_rdata", i), rdata, 32'(5 + i));
      chk($sformatf("ld%0d_last", i), rdata_last, (i == 3) ? 32'd1 : 32'd0);
      step();
      rdata_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("ld%0d_rdata_held", i), rdata, 32'(5 + i));
      chk($sformatf("ld%0d_rvalid_held", i), rdata_valid, 32'd1);
      step();
      rdata_ready = 1'b0;
    end
    @(negedge clk);
    chk("ld_done", done, 32'd1);
    chk("ld_strobes", 32'(rd_strobes - rd0), 32'd4);
    step();

    // Range and alignment table
    for (int v = 0; v < 9; v++) begin
      rd0 = rd_strobes;
      req_valid = 1'b1; req_write = 1'b0; req_addr = vecs[v].addr; req_len = vecs[v].len;
      rdata_ready = 1'b1;
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("rv%0d_err", v), err, 32'(vecs[v].exp_err));
      chk($sformatf("rv%0d_memread", v), memRead, 32'(!vecs[v].exp_err));
      chk($sformatf("rv%0d_addr", v), Address, vecs[v].exp_err ? 32'd0 : vecs[v].exp_addr);
      chk($sformatf("rv%0d_req_ready", v), req_ready, 32'(vecs[v].exp_err));
      repeat (2 * (int'(vecs[v].len) + 1)) step();
      @(negedge clk);
      chk($sformatf("rv%0d_done", v), done, 32'(!vecs[v].exp_err));
      chk($sformatf("rv%0d_err_clear", v), err, 32'd0);
      chk($sformatf("rv%0d_strobes", v), 32'(rd_strobes - rd0),
          vecs[v].exp_err ? 32'd0 : 32'(int'(vecs[v].len) + 1));
      step();
    end
    rdata_ready = 1'b0;

    // Store with a 3-cycle wdata_valid stall after the first word
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd1040; req_len = 4'd2;
    step();
    req_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 32'h0000_000A;
    @(negedge clk);
    chk("stall_w0_addr", Address, 32'd1040);
    chk("stall_w0_memwrite", memWrite, 32'd1);
    step();
    wdata_valid = 1'b0; wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_memwrite", i), memWrite, 32'd0);
      chk($sformatf("stall%0d_addr", i), Address, 32'd1044);
      chk($sformatf("stall%0d_wready", i), wdata_ready, 32'd1);
      step();
    end
    wdata_valid = 1'b1; wdata = 32'h0000_000B;
    @(negedge clk);
    chk("stall_w1_addr", Address, 32'd1044);
    chk("stall_w1_memwrite", memWrite, 32'd1);
    step();
    wdata = 32'h0000_000C;
    @(negedge clk);
    chk("stall_w2_addr", Address, 32'd1048);
    step();
    wdata_valid = 1'b0;
    @(negedge clk);
    chk("stall_done", done, 32'd1);
    chk("stall_mem4", mem[4], 32'h0000_000A);
    chk("stall_mem5", mem[5], 32'h0000_000B);
    chk("stall_mem6", mem[6], 32'h0000_000C);
    step();

    // Reset asserted after the second of four store words
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd1024; req_len = 4'd3;
    step();
    req_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 32'h0000_0011;
    step();
    wdata = 32'h0000_0022;
    step();
    wdata = 32'h0000_0033;
    rst = 1'b0;
    #1;
    chk("rstmid_ctl", ctl_bits(), 32'd0);
    chk("rstmid_addr", Address, 32'd0);
    step();
    step();
    rst = 1'b1;
    wdata_valid = 1'b0;
    chk("rstmid_mem0", mem[0], 32'h0000_0011);
    chk("rstmid_mem1", mem[1], 32'h0000_0022);
    chk("rstmid_mem2", mem[2], 32'd7);
    chk("rstmid_mem3", mem[3], 32'd8);
    step();
    @(negedge clk);
    chk("rstmid_ready", req_ready, 32'd1);
    chk("rstmid_no_done", done, 32'd0);
    step();

    // Fresh load returns the updated words
    rdata_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1024; req_len = 4'd1;
    step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    chk("reload_w0", rdata, 32'h0000_0011);
    chk("reload_w0_valid", rdata_valid, 32'd1);
    chk("reload_w0_last", rdata_last, 32'd0);
    step();
    step();
    @(negedge clk);
    chk("reload_w1", rdata, 32'h0000_0022);
    chk("reload_w1_last", rdata_last, 32'd1);
    step();
    @(negedge clk);
    chk("reload_done", done, 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Initiator for the word-addressed data memory in the ARM datapath. It accepts a block load/store request from the MEM stage (LDM/STM-style, 1–16 words), then sequences the per-word `memRead`/`memWrite`/`Address` accesses. Write data is pulled from a valid/ready stream and read data is pushed to one, so the pipeline can stall on either side. The block range-checks and word-aligns every access against the memory window that starts at byte address 1024.

## Interface
- `BASE_ADDR`, 1024: lowest legal byte address; memory word 0 sits here.
- `DEPTH`, 65536: memory words; highest legal aligned address is `BASE_ADDR + 4*(DEPTH-1)` = 263164.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: block request offered.
- `req_ready` out 1: block is idle and can accept a request.
- `req_write` in 1: 1 means store, 0 means load.
- `req_addr` in 32: start byte address; bits [1:0] are ignored.
- `req_len` in 4: word count minus 1 (0–15 gives 1–16 words).
- `wdata_valid` in 1, `wdata_ready` out 1, `wdata` in 32: store data stream.
- `rdata_valid` out 1, `rdata_ready` in 1, `rdata` out 32, `rdata_last` out 1: load data stream.
- `done` out 1: one-cycle pulse after the final word transfers.
- `err` out 1: one-cycle pulse when a request is rejected for range.
- `memRead` out 1, `memWrite` out 1, `Address` out 32, `writeData` out 32: data memory strobes and buses.
- `readData` in 32: data memory read bus (combinational from `Address`/`memRead`).

## Operation
- States: IDLE, READ, RD_OUT, WRITE.
- IDLE
  - `req_ready`=1.
  - On `req_valid`: latch `cur_addr = {req_addr[31:2],2'b00}`, `cnt = req_len`, and the direction.
  - Range check uses 33-bit arithmetic: reject if `cur_addr < BASE_ADDR` or `cur_addr + 4*req_len > BASE_ADDR + 4*(DEPTH-1)`.
  - On reject: `err` pulses next cycle, the block stays in IDLE, and no memory strobe is issued.
  - Otherwise go to READ or WRITE.
- READ
  - Drive `memRead`=1 and `Address=cur_addr`.
  - At the clock edge, register `readData` into `rdata` and `(cnt==0)` into `rdata_last`, then go to RD_OUT.
- RD_OUT
  - `memRead`=0 and `rdata_valid`=1; `rdata` and `rdata_last` are held stable until `rdata_ready`.
  - On handshake, if last: go to IDLE and pulse `done`.
  - On handshake, if not last: `cur_addr += 4`, `cnt -= 1`, go to READ.
- WRITE
  - `wdata_ready`=1.
  - `memWrite = wdata_valid` (combinational), `writeData = wdata`, `Address = cur_addr`.
  - Each handshake stores one word at that clock edge.
  - After a handshake, if `cnt==0`: go to IDLE and pulse `done`. Otherwise `cur_addr += 4`, `cnt -= 1`.
- `memRead` and `memWrite` are never high together. Both are 0 in IDLE and RD_OUT.
- `Address` reads 0 in IDLE. Its bits [1:0] are always 0.
- `req_valid` arriving while busy is ignored; the requester holds it until `req_ready`.

## Timing
- While `rst` is low, all outputs are 0, including `req_ready`. State is IDLE, `cnt`=0, `cur_addr`=0. `req_ready` rises in the first cycle after release.
- Reset asserted mid-burst aborts the burst immediately and asynchronously.
  - `memWrite` drops with reset, so no write occurs at the next edge.
  - No `done` pulse is produced.
  - Words already written stay written.
- Load latency: request accepted at edge E0 → READ in cycle 1 → `rdata_valid` in cycle 2.
  - Zero backpressure gives 2 cycles per word; an N-word load takes 2N cycles.
  - `done` goes high in the cycle after the last `rdata` handshake.
- Store throughput: 1 word per cycle while `wdata_valid` is held high. An N-word store completes N cycles after acceptance with no stalls; `done` follows the last write edge.
- `wdata_valid`=0 in WRITE: no write happens and the state holds.
- `done` and `err` are registered single-cycle pulses and are never both high.
- A new request can be accepted in the same cycle `done` is high (the block is already in IDLE).

## Test plan
- Store burst: `req_addr`=1024, `req_len`=3, `wdata` = 5, 6, 7, 8 streamed back to back → `memWrite` high for 4 consecutive cycles at `Address` 1024, 1028, 1032, 1036; `done` follows the 4th cycle.
- Load burst with backpressure: load the same block; `rdata_ready` toggles 0,1 → `rdata` = 5, 6, 7, 8 in order, each held while not ready; `rdata_last` set only with 8; `memRead` pulses exactly 4 times.
- Unaligned and range: `req_addr`=1030 → accesses at 1028. `req_addr`=1000 → `err` pulse, no strobe, `req_ready` stays 1. `req_addr`=263164 with `req_len`=0 → accepted. `req_addr`=263164 with `req_len`=1 → `err`.
- Store stall: `wdata_valid` low for 3 cycles mid-burst → `memWrite` stays 0 and `Address` holds the current word address; the burst resumes without skipping an address.
- Reset mid-store: drop `rst` after the 2nd of 4 words → outputs 0 immediately; memory at 1024 and 1028 is updated, 1032 and 1036 untouched; after release `req_ready`=1 and a fresh load returns the updated data.
